// File: rtl/seq_modmul_if.sv
// Operand/result bundle for seq_modmul. The master drives operands, the slave returns results.
interface seq_modmul_if #(
    parameter int WIDTH = 12
);
    // Handshake: an operand pair is taken on a rising edge where start_i && ready_o.
    // valid_o is high for exactly one cycle; prod_o/res_o then hold until the next result.
    logic               start_i;
    logic [WIDTH-1:0]   a_i;
    logic [WIDTH-1:0]   b_i;
    logic               ready_o;
    logic               valid_o;
    logic [2*WIDTH-1:0] prod_o;
    logic [WIDTH-1:0]   res_o;
    logic [2:0]         state_o;

    modport master (
        output start_i, a_i, b_i,
        input  ready_o, valid_o, prod_o, res_o, state_o
    );

    modport slave (
        input  start_i, a_i, b_i,
        output ready_o, valid_o, prod_o, res_o, state_o
    );
endinterface

// File: rtl/seq_modmul.sv
// Sequential shift-add multiplier (BPC multiplier bits per cycle) with optional
// Barrett reduction of the 2*WIDTH-bit product to [0,Q).
module seq_modmul #(
    parameter int WIDTH      = 12,
    parameter int Q          = 3329,
    parameter int BPC        = 1,
    parameter int REDUCE     = 1,
    parameter int EARLY_EXIT = 0
) (
    input  logic         clock_i,
    input  logic         nreset_i,
    seq_modmul_if.slave  bus
);
    localparam int N  = WIDTH / BPC;
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam int W2 = 2 * WIDTH;
    localparam int K  = W2;

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_MUL     = 3'd1;
    localparam logic [2:0] S_RED_Q   = 3'd2;
    localparam logic [2:0] S_RED_R   = 3'd3;
    localparam logic [2:0] S_RED_FIX = 3'd4;
    localparam logic [2:0] S_DONE    = 3'd5;

    localparam logic [K:0]       TWO_K    = {1'b1, {K{1'b0}}};
    localparam logic [K:0]       Q_K      = (K+1)'(Q);
    localparam logic [K:0]       M        = TWO_K / Q_K;
    localparam logic [W2-1:0]    Q_W2     = W2'(Q);
    localparam logic [WIDTH+1:0] Q_R      = (WIDTH+2)'(Q);
    localparam logic [WIDTH+1:0] Q2_R     = (WIDTH+2)'(2 * Q);
    localparam logic [CW-1:0]    LAST_CNT = CW'(N - 1);

    logic [2:0]       state_q, state_d;
    logic [W2-1:0]    a_sh_q, a_sh_d;
    logic [WIDTH-1:0] b_sh_q, b_sh_d;
    logic [W2-1:0]    acc_q, acc_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [W2-1:0]    qh_q, qh_d;
    logic [WIDTH+1:0] r_q, r_d;
    logic [W2-1:0]    prod_q, prod_d;
    logic [WIDTH-1:0] res_q, res_d;

    logic [WIDTH-1:0] b_next;
    logic [W2-1:0]    acc_mul;
    logic             last_digit;

    always_comb begin
        state_d = state_q;
        a_sh_d  = a_sh_q;
        b_sh_d  = b_sh_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        qh_d    = qh_q;
        r_d     = r_q;
        prod_d  = prod_q;
        res_d   = res_q;

        // The multiplicand is pre-shifted so each digit's weight is already applied.
        b_next     = b_sh_q >> BPC;
        acc_mul    = acc_q + a_sh_q * W2'(b_sh_q[BPC-1:0]);
        last_digit = (cnt_q == LAST_CNT) || ((EARLY_EXIT != 0) && (b_next == '0));

        case (state_q)
            S_IDLE, S_DONE: begin
                if (bus.start_i) begin
                    a_sh_d  = W2'(bus.a_i);
                    b_sh_d  = bus.b_i;
                    acc_d   = '0;
                    cnt_d   = '0;
                    state_d = S_MUL;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_MUL: begin
                acc_d  = acc_mul;
                a_sh_d = a_sh_q << BPC;
                b_sh_d = b_next;
                cnt_d  = cnt_q + 1'b1;
                if (last_digit) begin
                    if (REDUCE != 0) begin
                        state_d = S_RED_Q;
                    end else begin
                        prod_d  = acc_mul;
                        res_d   = acc_mul[WIDTH-1:0];
                        state_d = S_DONE;
                    end
                end
            end
            S_RED_Q: begin
                qh_d    = W2'(((2*W2+1)'(acc_q) * (2*W2+1)'(M)) >> K);
                state_d = S_RED_R;
            end
            S_RED_R: begin
                // Barrett error is at most two multiples of Q, so WIDTH+2 bits suffice.
                r_d     = (WIDTH+2)'(acc_q - qh_q * Q_W2);
                state_d = S_RED_FIX;
            end
            S_RED_FIX: begin
                if (r_q >= Q2_R) begin
                    res_d = WIDTH'(r_q - Q2_R);
                end else if (r_q >= Q_R) begin
                    res_d = WIDTH'(r_q - Q_R);
                end else begin
                    res_d = WIDTH'(r_q);
                end
                prod_d  = acc_q;
                state_d = S_DONE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock_i or negedge nreset_i) begin
        if (!nreset_i) begin
            state_q <= S_IDLE;
            a_sh_q  <= '0;
            b_sh_q  <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
            qh_q    <= '0;
            r_q     <= '0;
            prod_q  <= '0;
            res_q   <= '0;
        end else begin
            state_q <= state_d;
            a_sh_q  <= a_sh_d;
            b_sh_q  <= b_sh_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            qh_q    <= qh_d;
            r_q     <= r_d;
            prod_q  <= prod_d;
            res_q   <= res_d;
        end
    end

    assign bus.ready_o = (state_q == S_IDLE) || (state_q == S_DONE);
    assign bus.valid_o = (state_q == S_DONE);
    assign bus.prod_o  = prod_q;
    assign bus.res_o   = res_q;
    assign bus.state_o = state_q;
endmodule

// File: tb/tb_seq_modmul.sv
// Bench for seq_modmul: four parameterisations side by side (default, BPC=4,
// EARLY_EXIT=1, REDUCE=0), directed vectors, corner sequences and random operands.
module tb_seq_modmul;
    localparam int W  = 12;
    localparam int QM = 3329;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    int cfg_bpc [4] = '{1, 4, 1, 1};
    int cfg_red [4] = '{1, 1, 1, 0};
    int cfg_ee  [4] = '{0, 0, 1, 0};

    logic           start_v [4];
    logic [W-1:0]   a_v     [4];
    logic [W-1:0]   b_v     [4];
    logic           ready_v [4];
    logic           valid_v [4];
    logic [2*W-1:0] prod_v  [4];
    logic [W-1:0]   res_v   [4];
    logic [2:0]     state_v [4];

    seq_modmul_if #(.WIDTH(W)) bus [4] ();

    seq_modmul #(.WIDTH(W), .Q(QM), .BPC(1), .REDUCE(1), .EARLY_EXIT(0))
        dut0 (.clock_i(clk), .nreset_i(rst_n), .bus(bus[0]));
    seq_modmul #(.WIDTH(W), .Q(QM), .BPC(4), .REDUCE(1), .EARLY_EXIT(0))
        dut1 (.clock_i(clk), .nreset_i(rst_n), .bus(bus[1]));
    seq_modmul #(.WIDTH(W), .Q(QM), .BPC(1), .REDUCE(1), .EARLY_EXIT(1))
        dut2 (.clock_i(clk), .nreset_i(rst_n), .bus(bus[2]));
    seq_modmul #(.WIDTH(W), .Q(QM), .BPC(1), .REDUCE(0), .EARLY_EXIT(0))
        dut3 (.clock_i(clk), .nreset_i(rst_n), .bus(bus[3]));

    for (genvar g = 0; g < 4; g++) begin : g_wire
        assign bus[g].start_i = start_v[g];
        assign bus[g].a_i     = a_v[g];
        assign bus[g].b_i     = b_v[g];
        assign ready_v[g]     = bus[g].ready_o;
        assign valid_v[g]     = bus[g].valid_o;
        assign prod_v[g]      = bus[g].prod_o;
        assign res_v[g]       = bus[g].res_o;
        assign state_v[g]     = bus[g].state_o;
    end

    logic [3*W-1:0] exp_q [$];

    typedef struct {
        int             k;
        logic [W-1:0]   a;
        logic [W-1:0]   b;
        logic [2*W-1:0] prod;
        logic [W-1:0]   res;
        int             lat;
    } vec_t;

    vec_t vt [10];

    task automatic chk(input string name, input longint unsigned act, input longint unsigned exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    // Cycles from accept (cycle T) to the valid_o cycle, from the digit rules.
    function automatic int exp_lat(input int k, input logic [W-1:0] b);
        int n = W / cfg_bpc[k];
        int m = n;
        if (cfg_ee[k] != 0) begin
            m = 1;
            while (m < n && (b >> (cfg_bpc[k] * m)) != 0) m++;
        end
        return (cfg_red[k] != 0) ? m + 4 : m + 1;
    endfunction

    // Called at a negedge; returns at the negedge of the valid_o cycle.
    task automatic run_op(input int k, input logic [W-1:0] a, input logic [W-1:0] b,
                          output logic [2*W-1:0] prod, output logic [W-1:0] res, output int lat);
        int wait_n = 0;
        while (!ready_v[k] && wait_n < 64) begin
            @(posedge clk);
            @(negedge clk);
            wait_n++;
        end
        chk("ready_before_start", ready_v[k], 1);
        start_v[k] = 1'b1;
        a_v[k]     = a;
        b_v[k]     = b;
        @(posedge clk);
        lat = 1;
        @(negedge clk);
        start_v[k] = 1'b0;
        while (!valid_v[k] && lat < 64) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        prod = prod_v[k];
        res  = res_v[k];
    endtask

    task automatic check_op(input int k, input logic [W-1:0] a, input logic [W-1:0] b, input string tag);
        longint unsigned pa = a;
        longint unsigned pb = b;
        longint unsigned ep = pa * pb;
        longint unsigned er = (cfg_red[k] != 0) ? ep % QM : ep % (1 << W);
        logic [2*W-1:0]  p;
        logic [W-1:0]    r;
        logic [3*W-1:0]  e;
        int              lat;
        exp_q.push_back({ep[2*W-1:0], er[W-1:0]});
        run_op(k, a, b, p, r, lat);
        e = exp_q.pop_front();
        chk({tag, "_prod"}, p, e[3*W-1:W]);
        chk({tag, "_res"}, r, e[W-1:0]);
        chk({tag, "_lat"}, lat, exp_lat(k, b));
        if (cfg_red[k] != 0) chk({tag, "_res_lt_q"}, (r < QM), 1);
    endtask

    initial begin
        logic [2*W-1:0] p;
        logic [W-1:0]   r;
        logic [W-1:0]   ra, rb;
        int             lat;
        int             vcount;

        vt[0] = '{0, 12'd3328, 12'd3328, 24'd11075584, 12'd1,    16};
        vt[1] = '{0, 12'd1234, 12'd2345, 24'd2893730,  12'd829,  16};
        vt[2] = '{0, 12'd17,   12'd19,   24'd323,      12'd323,  16};
        vt[3] = '{0, 12'd0,    12'd4095, 24'd0,        12'd0,    16};
        vt[4] = '{1, 12'd4095, 12'd4095, 24'd16769025, 12'd852,  7};
        vt[5] = '{2, 12'd1000, 12'd0,    24'd0,        12'd0,    5};
        vt[6] = '{2, 12'd1000, 12'd3,    24'd3000,     12'd3000, 6};
        vt[7] = '{2, 12'd4095, 12'd4095, 24'd16769025, 12'd852,  16};
        vt[8] = '{3, 12'd3328, 12'd3328, 24'd11075584, 12'd0,    13};
        vt[9] = '{3, 12'd1234, 12'd2345, 24'd2893730,  12'd1954, 13};

        rst_n = 1'b0;
        for (int k = 0; k < 4; k++) begin
            start_v[k] = 1'b0;
            a_v[k]     = '0;
            b_v[k]     = '0;
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        for (int k = 0; k < 4; k++) begin
            chk("reset_ready", ready_v[k], 1);
            chk("reset_valid", valid_v[k], 0);
            chk("reset_prod", prod_v[k], 0);
            chk("reset_res", res_v[k], 0);
        end

        // Directed vectors, each followed by a check that valid_o lasts one cycle.
        for (int i = 0; i < 10; i++) begin
            run_op(vt[i].k, vt[i].a, vt[i].b, p, r, lat);
            chk("vec_prod", p, vt[i].prod);
            chk("vec_res", r, vt[i].res);
            chk("vec_lat", lat, vt[i].lat);
            @(posedge clk);
            @(negedge clk);
            chk("vec_valid_pulse", valid_v[vt[i].k], 0);
        end

        // Back-to-back: second start lands in the DONE cycle of the first.
        check_op(0, 12'd1234, 12'd2345, "b2b_first");
        check_op(0, 12'd17, 12'd19, "b2b_second");

        // start_i pulsed mid-MUL is ignored; previous result stays on the outputs.
        start_v[0] = 1'b1;
        a_v[0]     = 12'd100;
        b_v[0]     = 12'd200;
        @(posedge clk);
        lat = 1;
        @(negedge clk);
        start_v[0] = 1'b0;
        repeat (3) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        start_v[0] = 1'b1;
        a_v[0]     = 12'd4095;
        b_v[0]     = 12'd4095;
        @(posedge clk);
        lat++;
        @(negedge clk);
        start_v[0] = 1'b0;
        chk("midmul_held_prod", prod_v[0], 323);
        chk("midmul_ready", ready_v[0], 0);
        while (!valid_v[0] && lat < 64) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        chk("midmul_prod", prod_v[0], 20000);
        chk("midmul_res", res_v[0], 26);
        chk("midmul_lat", lat, 16);

        // Reset during RED_R (cycle T+14): no valid_o, outputs cleared, next op fine.
        @(posedge clk);
        @(negedge clk);
        start_v[0] = 1'b1;
        a_v[0]     = 12'd3000;
        b_v[0]     = 12'd3000;
        @(posedge clk);
        @(negedge clk);
        start_v[0] = 1'b0;
        repeat (13) begin
            @(posedge clk);
            @(negedge clk);
        end
        rst_n = 1'b0;
        #2;
        chk("midred_reset_valid", valid_v[0], 0);
        chk("midred_reset_ready", ready_v[0], 1);
        chk("midred_reset_prod", prod_v[0], 0);
        @(posedge clk);
        @(negedge clk);
        rst_n  = 1'b1;
        vcount = 0;
        repeat (20) begin
            @(posedge clk);
            @(negedge clk);
            if (valid_v[0]) vcount++;
        end
        chk("midred_no_valid", vcount, 0);
        check_op(0, 12'd17, 12'd19, "after_reset");

        // Random operands against the arithmetic model; small multipliers exercise early exit.
        for (int k = 0; k < 4; k++) begin
            for (int i = 0; i < 300; i++) begin
                ra = W'($urandom_range(0, (1 << W) - 1));
                if ($urandom_range(0, 3) == 0) rb = W'($urandom_range(0, 15));
                else                            rb = W'($urandom_range(0, (1 << W) - 1));
                check_op(k, ra, rb, "rand");
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end
endmodule
